// File: rtl/pnc_unit_endpoint.sv
// Responder end of the PNC unit bus: unit register bank, core access port and a
// show-ahead read-response FIFO back to the host.
module pnc_unit_endpoint #(
  parameter int DEPTH      = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             RC,
  input  logic             W_EN,
  input  logic [6:0]       Addr,
  input  logic [31:0]      Data,
  output logic             rsp_valid,
  output logic [6:0]       rsp_addr,
  output logic [31:0]      rsp_data,
  input  logic             rsp_ready,
  output logic [LVL_W-1:0] rsp_level,
  output logic             ovf,
  input  logic [6:0]       core_raddr,
  output logic [31:0]      core_rdata,
  input  logic             core_we,
  input  logic [6:0]       core_waddr,
  input  logic [31:0]      core_wdata,
  output logic             core_wr_drop
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [7:0]       DEPTH_L = 8'(DEPTH);
  localparam logic [LVL_W-1:0] FULL_L  = LVL_W'(FIFO_DEPTH);

  // ---------------- register bank ----------------
  logic [31:0] bank_q [DEPTH];

  logic bus_in_range;
  logic core_w_in_range;
  logic core_r_in_range;
  logic bus_we;
  logic bus_rd;
  logic core_hit;
  logic core_we_eff;
  logic core_wr_drop_d;
  logic core_wr_drop_q;

  assign bus_in_range    = ({1'b0, Addr} < DEPTH_L);
  assign core_w_in_range = ({1'b0, core_waddr} < DEPTH_L);
  assign core_r_in_range = ({1'b0, core_raddr} < DEPTH_L);

  assign bus_we         = EN & W_EN & bus_in_range;
  assign bus_rd         = EN & RC;
  assign core_hit       = core_we & core_w_in_range;
  // A core write colliding with a bus write to the same word loses.
  assign core_wr_drop_d = core_hit & bus_we & (core_waddr == Addr);
  assign core_we_eff    = core_hit & ~core_wr_drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus_we && (Addr == 7'(i))) begin
          bank_q[i] <= Data;
        end else if (core_we_eff && (core_waddr == 7'(i))) begin
          bank_q[i] <= core_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_wr_drop_q <= 1'b0;
    end else begin
      core_wr_drop_q <= core_wr_drop_d;
    end
  end

  assign core_wr_drop = core_wr_drop_q;
  assign core_rdata   = core_r_in_range ? bank_q[core_raddr] : 32'h0;

  // Read data is write-first for the bus command itself but sees the bank
  // before any core write landing on the same edge.
  logic [31:0] rd_data;
  always_comb begin
    rd_data = 32'h0;
    if (bus_in_range) begin
      rd_data = W_EN ? Data : bank_q[Addr];
    end
  end

  // ---------------- response FIFO ----------------
  // Handshake: the head {rsp_addr, rsp_data} is transferred on a rising edge
  // where rsp_valid && rsp_ready; rsp_ready while rsp_valid=0 is ignored and
  // rsp_valid never drops without a transfer except on reset.
  logic [6:0]       fifo_addr_q [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [6:0]       last_addr_q, last_addr_d;
  logic [31:0]      last_data_q, last_data_d;
  logic             ovf_q, ovf_d;
  logic             full;
  logic             pop;
  logic             push;

  assign rsp_valid = (cnt_q != '0);
  assign full      = (cnt_q == FULL_L);
  assign pop       = rsp_valid & rsp_ready;
  // When full, a same-edge pop frees the slot the push reuses.
  assign push      = bus_rd & (~full | pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    ovf_d       = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      last_addr_d = fifo_addr_q[rd_ptr_q];
      last_data_d = fifo_data_q[rd_ptr_q];
    end
    cnt_d = cnt_q + LVL_W'(push) - LVL_W'(pop);
    if (bus_rd && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      ovf_q       <= ovf_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= Addr;
        fifo_data_q[wr_ptr_q] <= rd_data;
      end
    end
  end

  // Empty FIFO keeps presenting the most recently consumed response.
  assign rsp_addr  = rsp_valid ? fifo_addr_q[rd_ptr_q] : last_addr_q;
  assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : last_data_q;
  assign rsp_level = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pnc_unit_endpoint.sv
// Bench for pnc_unit_endpoint: directed scenarios plus random traffic against a
// behavioural bank/response-queue model with a decoupled response monitor.
module tb_pnc_unit_endpoint;

  localparam int DEP = 120;
  localparam int FD  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN, RC, W_EN;
  logic [6:0]  Addr;
  logic [31:0] Data;
  logic        rsp_valid;
  logic [6:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic [2:0]  rsp_level;
  logic        ovf;
  logic [6:0]  core_raddr;
  logic [31:0] core_rdata;
  logic        core_we;
  logic [6:0]  core_waddr;
  logic [31:0] core_wdata;
  logic        core_wr_drop;

  pnc_unit_endpoint #(.DEPTH(DEP), .FIFO_DEPTH(FD), .LVL_W(3)) dut (
    .clk(clk), .rst(rst), .EN(EN), .RC(RC), .W_EN(W_EN), .Addr(Addr), .Data(Data),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .rsp_level(rsp_level), .ovf(ovf),
    .core_raddr(core_raddr), .core_rdata(core_rdata), .core_we(core_we),
    .core_waddr(core_waddr), .core_wdata(core_wdata), .core_wr_drop(core_wr_drop)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] bank_m [128];
  logic [38:0] exp_q [$];
  logic [38:0] last_m;
  int          cnt_m;
  bit          ovf_m;
  bit          drop_m;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) bank_m[i] = '0;
    exp_q.delete();
    last_m = '0;
    cnt_m  = 0;
    ovf_m  = 0;
    drop_m = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    EN = 0; RC = 0; W_EN = 0; Addr = '0; Data = '0;
    core_we = 0; core_waddr = '0; core_wdata = '0;
  endtask

  task automatic bus(bit en, bit rc, bit we, logic [6:0] a, logic [31:0] d);
    EN = en; RC = rc; W_EN = we; Addr = a; Data = d;
  endtask

  // Called at posedge+1 with inputs set; predicts the coming edge and checks after it.
  task automatic step();
    bit          bw, rd, pop, in_r;
    logic [31:0] rdat;
    #1;
    chk("core_rdata", core_rdata, (core_raddr < DEP) ? bank_m[core_raddr] : 32'h0);
    in_r = (Addr < DEP);
    bw   = EN && W_EN && in_r;
    rd   = EN && RC;
    pop  = (cnt_m > 0) && rsp_ready;
    rdat = !in_r ? 32'h0 : (W_EN ? Data : bank_m[Addr]);
    if (rd) begin
      if (cnt_m == FD && !pop) ovf_m = 1;
      else begin
        exp_q.push_back({Addr, rdat});
        cnt_m++;
      end
    end
    if (pop) cnt_m--;
    drop_m = core_we && (core_waddr < DEP) && bw && (core_waddr == Addr);
    if (core_we && (core_waddr < DEP) && !drop_m) bank_m[core_waddr] = core_wdata;
    if (bw) bank_m[Addr] = Data;
    @(posedge clk);
    #1;
    chk("rsp_level", rsp_level, cnt_m);
    chk("rsp_valid", rsp_valid, cnt_m > 0);
    chk("ovf", ovf, ovf_m);
    chk("core_wr_drop", core_wr_drop, drop_m);
    if (cnt_m == 0) chk("empty_hold", {rsp_addr, rsp_data}, last_m);
    else            chk("head_show", {rsp_addr, rsp_data}, exp_q[0]);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [38:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got addr %0d data 0x%0h, none expected", rsp_addr, rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_pop", {rsp_addr, rsp_data}, e);
          last_m = e;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; rsp_ready = 0; core_raddr = '0;
    idle();
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_addr", rsp_addr, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_level", rsp_level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", core_wr_drop, 0);

    // write then read, consume
    bus(1, 0, 1, 5, 32'hDEADBEEF); step();
    bus(1, 1, 0, 5, 0);            step();
    idle(); rsp_ready = 1;         step();
    step();

    // write+read in one command, core sees it next cycle
    bus(1, 1, 1, 9, 32'h12345678); step();
    idle(); core_raddr = 9;        step();

    // overflow: preload distinct data, then 5 reads with no consumer
    for (int i = 0; i < 5; i++) begin bus(1, 0, 1, 7'(i), 32'h100 + i); step(); end
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin bus(1, 1, 0, 7'(i), 0); step(); end
    idle(); rsp_ready = 1;
    for (int i = 0; i < 5; i++) step();

    // full + push with pop
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin bus(1, 1, 0, 7'(10 + i), 0); step(); end
    bus(1, 1, 0, 7, 0); rsp_ready = 1; step();
    idle();
    for (int i = 0; i < 5; i++) step();

    // bus/core write collision and non-collision
    bus(1, 0, 1, 3, 32'hA); core_we = 1; core_waddr = 3; core_wdata = 32'hB; step();
    idle(); core_raddr = 3; step();
    bus(1, 0, 1, 3, 32'hC); core_we = 1; core_waddr = 4; core_wdata = 32'hD; step();
    idle(); core_raddr = 4; step();

    // out-of-range write and read
    bus(1, 1, 1, 7'd125, 32'hFFFF); core_raddr = 7'd125; step();
    idle(); step();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      EN         = ($urandom_range(0, 3) != 0);
      RC         = $urandom_range(0, 1);
      W_EN       = $urandom_range(0, 1);
      Addr       = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      Data       = $urandom;
      core_we    = $urandom_range(0, 1);
      core_waddr = ($urandom_range(0, 2) == 0) ? Addr : 7'($urandom_range(0, 15));
      core_wdata = $urandom;
      core_raddr = 7'($urandom_range(0, 15));
      rsp_ready  = ($urandom_range(0, 2) != 0);
      step();
    end
    idle(); rsp_ready = 1;
    for (int i = 0; i < 6; i++) step();

    // asynchronous reset mid-operation
    rsp_ready = 0;
    bus(1, 1, 0, 2, 0); step();
    bus(1, 1, 0, 6, 0); step();
    bus(1, 0, 1, 1, 32'h55); step();
    idle();
    #1 rst = 1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_level", rsp_level, 0);
    chk("mid_rst_data", {rsp_addr, rsp_data}, 0);
    chk("mid_rst_ovf", ovf, 0);
    model_clear();
    @(posedge clk);
    #1 rst = 0;
    core_raddr = 1; rsp_ready = 1; step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pnc_unit_endpoint.md
Name: pnc_unit_endpoint

Overview:
Responder end of the Physical Neuron Controller unit bus: one instance sits in front of each neuron unit (SYNAPSE, SOMA, STDP) and consumes the EN / RC / W_EN / 7-bit address / 32-bit data strobes the controller drives.
- Holds the unit's parameter/state register bank.
- Lets the unit core read and update that bank.
- Returns bus read data to the host through a small show-ahead response FIFO with valid/ready handshake, closing the read path the controller opens.

Parameters:
DEPTH, 128, register bank words; legal addresses 0..DEPTH-1 (max 128).
FIFO_DEPTH, 4, response FIFO entries (power of two, >=2).
LVL_W, 3, width of rsp_level; holds 0..FIFO_DEPTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
EN  in  1  unit select; bus command valid this cycle.
RC  in  1  read command.
W_EN  in  1  write command.
Addr  in  7  bus word address.
Data  in  32  bus write data.
rsp_valid  out  1  response FIFO head valid.
rsp_addr  out  7  address of head response.
rsp_data  out  32  data of head response.
rsp_ready  in  1  host consumes head when rsp_valid=1.
rsp_level  out  LVL_W  current FIFO occupancy.
ovf  out  1  sticky: a read response was dropped.
core_raddr  in  7  core read address.
core_rdata  out  32  bank[core_raddr], combinational; 0 if out of range.
core_we  in  1  core write strobe.
core_waddr  in  7  core write address.
core_wdata  in  32  core write data.
core_wr_drop  out  1  registered pulse: core write lost to bus write.

Behaviour:
- Reset (async, rst=1):
  - all bank words 0; FIFO empty.
  - rsp_valid=0, rsp_addr=0, rsp_data=0, rsp_level=0, ovf=0, core_wr_drop=0.
- Command decode, sampled at rising edge with EN=1 (EN=0: RC, W_EN, Addr, Data ignored):
  - W_EN=1, RC=0: write Data to bank[Addr].
  - W_EN=0, RC=1: read.
  - W_EN=1, RC=1: write, then read; response carries the new Data (write-first).
  - W_EN=0, RC=0: no-op.
- Out-of-range Addr (>=DEPTH): write ignored; read still produces a response, data=0.
- Read latency:
  - Read sampled at edge t pushes {Addr, data} at edge t.
  - rsp_valid=1 in cycle after t if FIFO was empty.
  - Data is the bank value before any core write in the same edge (read-before-write for core writes).
- FIFO, show-ahead: rsp_addr/rsp_data always present the head.
  - Pop on edge when rsp_valid & rsp_ready.
  - rsp_ready with rsp_valid=0 has no effect.
  - Empty: rsp_addr/rsp_data hold last popped values (0 after reset).
- Full (level=FIFO_DEPTH):
  - Push with simultaneous pop: accepted; level unchanged.
  - Push without pop: response dropped; ovf set to 1 and held until rst.
  - Bank write side of a W_EN&RC command always completes.
- Empty: simultaneous push and pop cannot occur (rsp_valid=0); push alone raises level to 1.
- Core write:
  - core_we=1 writes core_wdata to bank[core_waddr] at the edge; out-of-range ignored.
  - Same edge as bus write to a different address: both written.
  - Same edge as bus write to the same address: bus wins; core_wr_drop=1 for the following cycle, else 0.
- core_rdata: combinational; reflects writes from the next cycle on.
- Pointers wrap modulo FIFO_DEPTH; rsp_level = pushes - pops.
- rst asserted mid-operation: pending responses discarded, bank cleared; no partial response emitted after release.

Test Plan:
- Reset, bus write EN=1,W_EN=1,Addr=5,Data=0xDEADBEEF, then EN=1,RC=1,Addr=5 -> next cycle rsp_valid=1, rsp_addr=5, rsp_data=0xDEADBEEF, rsp_level=1; rsp_ready=1 -> level 0, rsp_valid=0.
- EN=1,W_EN=1,RC=1,Addr=9,Data=0x12345678 in one cycle -> bank[9]=0x12345678, response data 0x12345678; core_raddr=9 reads 0x12345678 following cycle.
- rsp_ready=0; 5 back-to-back reads of addr 0..4 -> first 4 queued in order, 5th dropped, ovf=1, level=4. Drain 4 -> data order 0..3; ovf stays 1 until rst.
- Level=4; read of addr 7 in same cycle as pop -> level stays 4; new tail is addr 7.
- Bus write Addr=3,Data=0xA and core_we Addr=3,wdata=0xB same edge -> bank[3]=0xA, core_wr_drop pulses 1 cycle. Core write Addr=4 same edge as bus write Addr=3 -> both written, no pulse.
- Queue 2 responses, write bank[1]=0x55, assert rst asynchronously mid-cycle -> outputs zero immediately, level=0, bank[1]=0 after release.
